// File: rtl/image_pkg.sv
// Shared constants and state type for the output image writer.
// Geometry defaults assume a 32x32 input image reduced by a 3x3 window.
package image_pkg;

   localparam int IMG_COLS     = 32;
   localparam int WIN_BORDER   = 2;
   localparam int DEF_OUT_COLS = IMG_COLS - WIN_BORDER;
   localparam int DEF_OUT_ROWS = IMG_COLS - WIN_BORDER;
   localparam int ADDR_W       = 10;
   localparam int PIX_W        = 8;
   localparam int DATA_W       = 16;
   localparam int CNT_W        = 5;
   localparam int RAM_DEPTH    = 1 << ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/result_ram.sv
// Result frame store: 1024x8, one synchronous write port and one
// asynchronous read port. Contents are never reset.
module result_ram
   import image_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [PIX_W-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [PIX_W-1:0]  rd_data
);

   logic [PIX_W-1:0] mem [RAM_DEPTH];

   // Write on the clock edge; a same-cycle read sees the old word.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/output_image_writer.sv
// Captures one frame of convolution results into result_ram, row-major.
// Define CLAMP_EN to saturate pixels to 0..255 instead of truncating.
module output_image_writer
   import image_pkg::*;
#(
   parameter int OUT_COLS = DEF_OUT_COLS,
   parameter int OUT_ROWS = DEF_OUT_ROWS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [PIX_W-1:0]  rd_data,
   output logic [CNT_W-1:0]  wr_col,
   output logic [CNT_W-1:0]  wr_row,
   output logic              busy,
   output logic              done,
   output logic              err_drop
);

   localparam int FRAME = OUT_COLS * OUT_ROWS;
   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(OUT_COLS - 1);
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(OUT_ROWS - 1);
   localparam logic [ADDR_W:0] FRAME_END = (ADDR_W + 1)'(FRAME);

   state_t            state;
   logic [ADDR_W-1:0] wr_addr;
   logic              hs;
   logic [PIX_W-1:0]  pix;
   logic [PIX_W-1:0]  ram_q;

   assign in_ready = (state == ST_ACTIVE);
   assign busy     = (state == ST_ACTIVE);
   assign done     = (state == ST_DONE);
   assign hs       = in_valid & in_ready;

`ifdef CLAMP_EN
   // Saturate the signed sum into the unsigned pixel range.
   always_comb begin
      pix = in_data[PIX_W-1:0];
      if (in_data[DATA_W-1]) begin
         pix = '0;
      end else if (|in_data[DATA_W-2:PIX_W]) begin
         pix = '1;
      end
   end
`else
   logic unused_hi;
   assign unused_hi = ^in_data[DATA_W-1:PIX_W];
   assign pix       = in_data[PIX_W-1:0];
`endif

   // Frame FSM, raster counters and sticky drop flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         wr_col   <= '0;
         wr_row   <= '0;
         wr_addr  <= '0;
         err_drop <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  wr_col   <= '0;
                  wr_row   <= '0;
                  wr_addr  <= '0;
                  err_drop <= 1'b0;
                  state    <= ST_ACTIVE;
               end else if (in_valid) begin
                  err_drop <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (hs) begin
                  wr_addr <= wr_addr + 1'b1;
                  if (wr_col == LAST_COL) begin
                     wr_col <= '0;
                     wr_row <= wr_row + 1'b1;
                     if (wr_row == LAST_ROW) begin
                        state <= ST_DONE;
                     end
                  end else begin
                     wr_col <= wr_col + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               if (in_valid) begin
                  err_drop <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   result_ram u_ram (
      .clk     (clk),
      .we      (hs),
      .wr_addr (wr_addr),
      .wr_data (pix),
      .rd_addr (rd_addr),
      .rd_data (ram_q)
   );

   assign rd_data = ({1'b0, rd_addr} < FRAME_END) ? ram_q : '0;

endmodule

// File: doc/output_image_writer.md
OUTPUT_IMAGE_WRITER -- requirements
Module: output_image_writer

Interface
REQ-001 SHALL have parameter OUT_COLS, default 30, output image width in pixels (32-pixel input minus 3x3 window border).
REQ-002 SHALL have parameter OUT_ROWS, default 30, output image height in pixels.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that arms capture of one frame.
REQ-006 SHALL have port in_valid  input  1  result pixel present on in_data.
REQ-007 SHALL have port in_data  input  16  signed two's-complement convolution sum.
REQ-008 SHALL have port in_ready  output  1  writer accepts a pixel this cycle.
REQ-009 SHALL have port rd_addr  input  10  read-back address, row-major linear.
REQ-010 SHALL have port rd_data  output  8  stored pixel at rd_addr.
REQ-011 SHALL have port wr_col  output  5  column of the next pixel to be written.
REQ-012 SHALL have port wr_row  output  5  row of the next pixel to be written.
REQ-013 SHALL have port busy  output  1  high while a frame is being captured.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the last pixel of a frame is written.
REQ-015 SHALL have port err_drop  output  1  sticky flag: in_valid seen while not armed.

Function
REQ-016 SHALL implement the states IDLE, ACTIVE and DONE.
REQ-017 In IDLE, start SHALL clear wr_col, wr_row and the write address, then enter ACTIVE on the next edge.
REQ-018 In ACTIVE, in_ready SHALL be 1 and busy SHALL be 1; in all other states both SHALL be 0.
REQ-019 A handshake (in_valid & in_ready) SHALL write the 8-bit pixel to ram[wr_col + OUT_COLS*wr_row] on that edge, with zero-cycle latency.
REQ-020 After each handshake wr_col SHALL increment; when wr_col = OUT_COLS-1 it SHALL wrap to 0 and wr_row SHALL increment.
REQ-021 The handshake at wr_col = OUT_COLS-1 and wr_row = OUT_ROWS-1 SHALL move the block to DONE.
REQ-022 DONE SHALL last exactly one cycle with done = 1, then return to IDLE.
REQ-023 start SHALL be ignored in ACTIVE and in DONE.
REQ-024 in_valid while in IDLE or DONE SHALL be dropped with no write, and SHALL set err_drop.
REQ-025 err_drop SHALL clear only on reset or on an accepted start.
REQ-026 rd_data SHALL be combinational from rd_addr.
REQ-027 rd_addr >= OUT_COLS*OUT_ROWS SHALL read 0.
REQ-028 A read of the address being written in the same cycle SHALL return the pre-write value.
REQ-029 Gaps in in_valid SHALL leave all counters unchanged.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, wr_col 0, wr_row 0, write address 0, in_ready 0, busy 0, done 0, err_drop 0.
REQ-031 Reset SHALL NOT clear RAM contents.
REQ-032 Reset during ACTIVE SHALL abort the frame; already-written pixels remain, and no done pulse SHALL be issued.

Configuration
REQ-033 With CLAMP_EN defined, the stored pixel SHALL be in_data saturated to 0..255: negative values give 0, values above 255 give 255.
REQ-034 Without CLAMP_EN, the stored pixel SHALL be in_data[7:0] (truncation).

Structure
REQ-035 Package image_pkg SHALL hold IMG_COLS = 32, the default OUT_COLS/OUT_ROWS, ADDR_W = 10, PIX_W = 8, and the state enum.
REQ-036 Storage SHALL be a sub-module result_ram: 1024x8, one synchronous write port, one combinational read port.
REQ-037 The FSM, counters and clamp logic SHALL reside in output_image_writer.

Verification
REQ-038 Reset, then start, then 900 back-to-back pixels of value k mod 256 (k = 0..899) -> done is high for one cycle after pixel 899; reading addr 31 returns 0x1F (row 1, col 1 = addr 31 under OUT_COLS = 30).
REQ-039 in_valid toggled every other cycle for a full frame -> done asserts after the 900th handshake; wr_row/wr_col step 0/29 -> 1/0 exactly at handshake 30.
REQ-040 CLAMP_EN defined: inputs -5, 300, 128 -> stored values 0, 255, 128; CLAMP_EN undefined: same inputs -> 0xFB, 0x2C, 0x80.
REQ-041 in_valid asserted in IDLE with in_data 0x55 -> no RAM change and err_drop = 1; next start -> err_drop = 0.
REQ-042 rst_n pulsed low after 450 pixels -> all outputs go to reset values at once, addresses 0..449 keep their data, and no done pulse occurs.
REQ-043 start pulsed mid-frame, and rd_addr = 900 -> capture continues unchanged, and rd_data = 0.
